// File: rtl/output_vote_generator_pkg.sv
// Shared definitions for the output vote generator.
// Holds the default sizing constants, the FSM state type and the index
// helpers for the flattened vote (o_p_o) and grant (i_p_r) vectors.
package fpf_pkg;

    localparam int N  = 24;
    localparam int P  = 8;
    localparam int LW = 8;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic {
        ST_VOTE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_e;

    // Bit position of output n's vote for input i at priority j.
    function automatic int po_idx(input int n, input int j, input int i,
                                  input int nn, input int pp);
        return n * pp * nn + j * nn + i;
    endfunction

    // Bit position of the grant for input i at priority j.
    function automatic int pr_idx(input int j, input int i, input int nn);
        return j * nn + i;
    endfunction

endpackage

// File: rtl/output_vote_generator_if.sv
// Request / vote / grant bundle between the input queues, the mask stage
// and the output vote generator.
//   master : drives requests (valid, prio, dest, len) and grants (i_p_r)
//   slave  : the vote generator; drives votes, dequeue pulses, busy, error
interface output_vote_generator_if #(
    parameter int N  = fpf_pkg::N,
    parameter int P  = fpf_pkg::P,
    parameter int LW = fpf_pkg::LW
);
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    logic [N-1:0]      i_valid;
    logic [N*PW-1:0]   i_prio;
    logic [N*N-1:0]    i_dest;
    logic [N*LW-1:0]   i_len;
    logic [N*P-1:0]    i_p_r;
    logic [N*N*P-1:0]  o_p_o;
    logic [N-1:0]      o_deq;
    logic [N-1:0]      o_busy;
    logic              o_err;

    modport master (
        output i_valid, i_prio, i_dest, i_len, i_p_r,
        input  o_p_o, o_deq, o_busy, o_err
    );

    modport slave (
        input  i_valid, i_prio, i_dest, i_len, i_p_r,
        output o_p_o, o_deq, o_busy, o_err
    );

endinterface

// File: rtl/output_vote_generator_picker.sv
// Winner selection for one output.
//   cand   : candidate mask, one bit per input
//   prio   : flattened per-input priority fields
//   ptr    : round-robin start index
//   found  : at least one candidate present
//   winner : highest-priority candidate, first at or after ptr (wrapping)
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int PW = 2,
    parameter int IW = 2
) (
    input  logic [N-1:0]    cand,
    input  logic [N*PW-1:0] prio,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   winner
);
    logic [PW-1:0] max_p;
    int            d;
    int            best_d;

    always_comb begin
        max_p  = '0;
        found  = |cand;
        winner = '0;
        best_d = N;
        d      = 0;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && prio[i*PW +: PW] > max_p) max_p = prio[i*PW +: PW];
        end
        // Rotational distance from ptr; the smallest one wins among the top level.
        for (int i = 0; i < N; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + N;
            if (cand[i] && prio[i*PW +: PW] == max_p && d < best_d) begin
                best_d = d;
                winner = IW'(i);
            end
        end
    end

endmodule

// File: rtl/output_vote_generator.sv
// Output vote generator: every two cycles elects one winner per idle output,
// publishes votes for the mask stage, then commits the returned grants by
// popping inputs and occupying their destination outputs.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : requests in, grants in, votes / deq / busy / err out
//
//   state     | meaning
//   ST_VOTE   | snapshot requests, compute and register votes
//   ST_COMMIT | votes visible, check grants, load busy counters
module output_vote_generator #(
    parameter int N  = fpf_pkg::N,
    parameter int P  = fpf_pkg::P,
    parameter int LW = fpf_pkg::LW
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output_vote_generator_if.slave  bus
);
    import fpf_pkg::*;

    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_e            state;
    logic [N-1:0]      valid_q;
    logic [N*PW-1:0]   prio_q;
    logic [N*N-1:0]    dest_q;
    logic [N*LW-1:0]   len_q;
    logic [N*N*P-1:0]  p_o_q;
    logic [N-1:0]      deq_q;
    logic              err_q;
    logic [LW-1:0]     busy_cnt [N];
    logic [IW-1:0]     rr_ptr   [N];

    logic [N-1:0]      req_ok;
    logic [N*N-1:0]    cand;
    logic [N-1:0]      found;
    logic [IW-1:0]     winner   [N];
    logic [N*N*P-1:0]  votes;
    logic [N-1:0]      busy_vec;

    logic [N-1:0]      grant;
    logic              err_now;
    logic [N-1:0]      load_en;
    logic [LW-1:0]     load_val [N];
    logic [IW-1:0]     ptr_new  [N];
    logic [P-1:0]      col;
    logic              bad;

    always_comb begin
        req_ok = '0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            req_ok[i] = bus.i_valid[i] && (bus.i_dest[i*N +: N] != '0);
        end
        for (int n = 0; n < N; n++) begin
            for (int i = 0; i < N; i++) begin
                cand[n*N + i] = req_ok[i] && bus.i_dest[i*N + n];
            end
        end
    end

    for (genvar n = 0; n < N; n++) begin : g_pick
        rr_priority_picker #(.N(N), .PW(PW), .IW(IW)) u_pick (
            .cand   (cand[n*N +: N]),
            .prio   (bus.i_prio),
            .ptr    (rr_ptr[n]),
            .found  (found[n]),
            .winner (winner[n])
        );
    end

    // Outputs outside an input's destination set approve it unconditionally,
    // so the mask stage can simply AND the votes across all outputs.
    always_comb begin
        votes = '0;
        for (int n = 0; n < N; n++) begin
            for (int j = 0; j < P; j++) begin
                for (int i = 0; i < N; i++) begin
                    if (req_ok[i] && bus.i_prio[i*PW +: PW] == PW'(j) &&
                        (!bus.i_dest[i*N + n] ||
                         (busy_cnt[n] == '0 && found[n] && winner[n] == IW'(i)))) begin
                        votes[po_idx(n, j, i, N, P)] = 1'b1;
                    end
                end
            end
        end
    end

    // A grant is honoured only if it matches the snapshot request and every
    // destination output actually voted for it; anything else is an error.
    always_comb begin
        grant   = '0;
        err_now = 1'b0;
        load_en = '0;
        col     = '0;
        bad     = 1'b0;
        for (int n = 0; n < N; n++) begin
            load_val[n] = '0;
            ptr_new[n]  = '0;
        end
        if (state == ST_COMMIT) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < P; j++) col[j] = bus.i_p_r[pr_idx(j, i, N)];
                bad = !valid_q[i] || (dest_q[i*N +: N] == '0) ||
                      ((col & (col - P'(1))) != '0);
                for (int j = 0; j < P; j++) begin
                    if (col[j]) begin
                        if (PW'(j) != prio_q[i*PW +: PW]) bad = 1'b1;
                        for (int n = 0; n < N; n++) begin
                            if (dest_q[i*N + n] && !p_o_q[po_idx(n, j, i, N, P)]) bad = 1'b1;
                        end
                    end
                end
                if (col != '0) begin
                    if (bad) err_now  = 1'b1;
                    else     grant[i] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int n = 0; n < N; n++) begin
                    if (grant[i] && dest_q[i*N + n]) begin
                        load_en[n]  = 1'b1;
                        load_val[n] = (len_q[i*LW +: LW] == '0) ? LW'(1) : len_q[i*LW +: LW];
                        ptr_new[n]  = (i == N - 1) ? '0 : IW'(i + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_VOTE;
            valid_q <= '0;
            prio_q  <= '0;
            dest_q  <= '0;
            len_q   <= '0;
            p_o_q   <= '0;
            deq_q   <= '0;
            err_q   <= 1'b0;
            for (int n = 0; n < N; n++) begin
                busy_cnt[n] <= '0;
                rr_ptr[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < N; n++) begin
                if (load_en[n]) begin
                    busy_cnt[n] <= load_val[n];
                    rr_ptr[n]   <= ptr_new[n];
                end else if (busy_cnt[n] != '0) begin
                    busy_cnt[n] <= busy_cnt[n] - LW'(1);
                end
            end
            case (state)
                ST_VOTE: begin
                    state   <= ST_COMMIT;
                    valid_q <= bus.i_valid;
                    prio_q  <= bus.i_prio;
                    dest_q  <= bus.i_dest;
                    len_q   <= bus.i_len;
                    p_o_q   <= votes;
                    deq_q   <= '0;
                end
                default: begin
                    state <= ST_VOTE;
                    p_o_q <= '0;
                    deq_q <= grant;
                    if (err_now) err_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int n = 0; n < N; n++) busy_vec[n] = (busy_cnt[n] != '0);
    end

    assign bus.o_p_o  = p_o_q;
    assign bus.o_deq  = deq_q;
    assign bus.o_busy = busy_vec;
    assign bus.o_err  = err_q;

endmodule

// File: tb/tb_output_vote_generator.sv
// Directed bench for output_vote_generator with N=4, P=4, LW=4. The mask
// stage is modelled here: input i is granted at priority j when every
// output's vote bit for (j, i) is set. Cycle 0 is the first VOTE cycle
// after reset; comments give the cycle each step lands in.
module tb_output_vote_generator;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int LW = 4;
    localparam int PW = 2;

    logic clk;
    logic rst;
    logic [N*P-1:0] force_pr;
    logic [N*P-1:0] mask_pr;
    int passed;
    int total;

    output_vote_generator_if #(.N(N), .P(P), .LW(LW)) bus ();

    output_vote_generator #(.N(N), .P(P), .LW(LW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mask_pr = '0;
        for (int j = 0; j < P; j++) begin
            for (int i = 0; i < N; i++) begin
                mask_pr[j*N + i] = 1'b1;
                for (int n = 0; n < N; n++) begin
                    if (!bus.o_p_o[fpf_pkg::po_idx(n, j, i, N, P)]) mask_pr[j*N + i] = 1'b0;
                end
            end
        end
        bus.i_p_r = mask_pr | force_pr;
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic v, input int pr,
                           input logic [N-1:0] dest, input int len);
        bus.i_valid[i]            = v;
        bus.i_prio[i*PW +: PW]    = PW'(pr);
        bus.i_dest[i*N +: N]      = dest;
        bus.i_len[i*LW +: LW]     = LW'(len);
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        force_pr    = '0;
        rst         = 1'b1;
        bus.i_valid = '0;
        bus.i_prio  = '0;
        bus.i_dest  = '0;
        bus.i_len   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // cycle 0: reset state
        chk("rst_p_o",  bus.o_p_o,  64'h0);
        chk("rst_deq",  bus.o_deq,  64'h0);
        chk("rst_busy", bus.o_busy, 64'h0);
        chk("rst_err",  bus.o_err,  64'h0);

        // unicast: input 2, prio 3, dest 0001, len 3
        set_req(2, 1'b1, 3, 4'b0001, 3);
        tick(1);                                   // cycle 1
        set_req(2, 1'b0, 0, 4'b0000, 0);
        chk("uni_votes", bus.o_p_o, 64'h4000_4000_4000_4000);
        chk("uni_deq_c1", bus.o_deq, 64'h0);
        tick(1);                                   // cycle 2
        chk("uni_deq_c2", bus.o_deq, 64'h4);
        chk("uni_busy_c2", bus.o_busy, 64'h1);
        chk("uni_p_o_vote", bus.o_p_o, 64'h0);
        tick(1);                                   // cycle 3
        chk("uni_busy_c3", bus.o_busy, 64'h1);
        chk("uni_deq_c3", bus.o_deq, 64'h0);
        tick(1);                                   // cycle 4
        chk("uni_busy_c4", bus.o_busy, 64'h1);
        tick(1);                                   // cycle 5
        chk("uni_busy_c5", bus.o_busy, 64'h0);
        tick(1);                                   // cycle 6

        // priority conflict on output 1
        set_req(0, 1'b1, 1, 4'b0010, 2);
        set_req(1, 1'b1, 3, 4'b0010, 2);
        tick(1);                                   // cycle 7
        chk("pri_votes", bus.o_p_o, 64'h2010_2010_2000_2010);
        tick(1);                                   // cycle 8
        chk("pri_deq_hi", bus.o_deq, 64'h2);
        chk("pri_busy", bus.o_busy, 64'h2);
        set_req(1, 1'b0, 0, 4'b0000, 0);
        tick(2);                                   // cycle 10
        chk("pri_deq_wait", bus.o_deq, 64'h0);
        chk("pri_idle", bus.o_busy, 64'h0);
        tick(2);                                   // cycle 12
        chk("pri_deq_lo", bus.o_deq, 64'h1);
        chk("pri_busy_lo", bus.o_busy, 64'h2);
        set_req(0, 1'b0, 0, 4'b0000, 0);
        tick(2);                                   // cycle 14
        chk("pri_end_busy", bus.o_busy, 64'h0);

        // round-robin on output 2, requests held
        set_req(0, 1'b1, 2, 4'b0100, 1);
        set_req(3, 1'b1, 2, 4'b0100, 1);
        tick(2);                                   // cycle 16
        chk("rr_g0", bus.o_deq, 64'h1);
        chk("rr_busy", bus.o_busy, 64'h4);
        tick(2);                                   // cycle 18
        chk("rr_gap", bus.o_deq, 64'h0);
        tick(2);                                   // cycle 20
        chk("rr_g1", bus.o_deq, 64'h8);
        tick(4);                                   // cycle 24
        chk("rr_g2", bus.o_deq, 64'h1);
        tick(4);                                   // cycle 28
        chk("rr_g3", bus.o_deq, 64'h8);
        set_req(0, 1'b0, 0, 4'b0000, 0);
        set_req(3, 1'b0, 0, 4'b0000, 0);
        tick(2);                                   // cycle 30

        // multicast blocked by busy output 0
        set_req(2, 1'b1, 0, 4'b0001, 4);
        tick(2);                                   // cycle 32
        chk("mc_block_deq", bus.o_deq, 64'h4);
        set_req(2, 1'b0, 0, 4'b0000, 0);
        set_req(1, 1'b1, 2, 4'b0011, 2);
        tick(1);                                   // cycle 33
        chk("mc_vote_busy", bus.o_p_o[9], 64'h0);
        chk("mc_vote_idle", bus.o_p_o[25], 64'h1);
        tick(1);                                   // cycle 34
        chk("mc_no_deq", bus.o_deq, 64'h0);
        chk("mc_out1_idle", bus.o_busy, 64'h1);
        tick(2);                                   // cycle 36
        chk("mc_freed", bus.o_busy, 64'h0);
        chk("mc_no_deq2", bus.o_deq, 64'h0);
        tick(2);                                   // cycle 38
        chk("mc_deq", bus.o_deq, 64'h2);
        chk("mc_busy", bus.o_busy, 64'h3);
        chk("mc_err", bus.o_err, 64'h0);
        set_req(1, 1'b0, 0, 4'b0000, 0);
        tick(2);                                   // cycle 40

        // forced grant on an unvoted input
        tick(1);                                   // cycle 41
        force_pr = 16'h0001;
        tick(1);                                   // cycle 42
        force_pr = '0;
        chk("err_set", bus.o_err, 64'h1);
        chk("err_no_deq", bus.o_deq, 64'h0);
        tick(1);                                   // cycle 43
        chk("err_sticky", bus.o_err, 64'h1);
        tick(1);                                   // cycle 44

        // reset during COMMIT drops the grant
        set_req(2, 1'b1, 1, 4'b0100, 3);
        tick(1);                                   // cycle 45
        chk("rc_vote", bus.o_p_o[38], 64'h1);
        set_req(2, 1'b0, 0, 4'b0000, 0);
        rst = 1'b1;
        tick(1);                                   // cycle 46
        rst = 1'b0;
        chk("rc_deq", bus.o_deq, 64'h0);
        chk("rc_busy", bus.o_busy, 64'h0);
        chk("rc_err", bus.o_err, 64'h0);
        chk("rc_p_o", bus.o_p_o, 64'h0);
        tick(1);                                   // cycle 47
        chk("rc_busy2", bus.o_busy, 64'h0);
        tick(1);                                   // cycle 48
        chk("rc_deq2", bus.o_deq, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/output_vote_generator.md
OUTPUT_VOTE_GENERATOR -- requirements
Module: output_vote_generator

Interface
REQ-001 Parameter N, default 24: number of input ports and number of output ports.
REQ-002 Parameter P, default 8: number of priority levels; level P-1 is highest.
REQ-003 Parameter LW, default 8: width of the packet-length field.
REQ-004 Derived constant PW = clog2(P): width of the priority field.
REQ-005 i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 i_rst  in  1  reset, synchronous and active-high.
REQ-007 i_valid  in  N  bit i: input i presents a head packet.
REQ-008 i_prio  in  N*PW  field i: priority of input i's head packet.
REQ-009 i_dest  in  N*N  bit i*N+n: input i's packet targets output n (multicast allowed).
REQ-010 i_len  in  N*LW  field i: output occupancy in cycles; 0 is treated as 1.
REQ-011 i_p_r  in  N*P  grant vector from the mask stage; bit j*N+i means input i is granted at priority j.
REQ-012 o_p_o  out  N*N*P  vote vector; bit n*P*N+j*N+i is output n's approval of input i at priority j.
REQ-013 o_deq  out  N  one-cycle pulse per input; input i pops its head packet.
REQ-014 o_busy  out  N  bit n: output n is occupied.
REQ-015 o_err  out  1  sticky flag for an inconsistent grant.

Function
REQ-016 The control FSM has two states: VOTE and COMMIT. It alternates VOTE->COMMIT->VOTE unconditionally, giving one arbitration every 2 cycles.
REQ-017 In VOTE, the block snapshots i_valid, i_prio, i_dest and i_len into registers.
REQ-018 In VOTE, the block computes votes, registers them into o_p_o, and presents them throughout the following COMMIT cycle.
REQ-019 Candidate set for output n: all inputs i with valid[i]=1, dest[i][n]=1 and dest[i]!=0.
REQ-020 Output n is idle when its busy counter equals 0.
REQ-021 When output n is idle and its candidate set is non-empty, the winner is chosen as follows:
  - take the candidates at the maximum priority;
  - among those, pick the first index at or after rr_ptr[n], wrapping modulo N.
REQ-022 Vote bit [n][j][i] is 1 only when all of the following hold:
  - valid[i]=1;
  - dest[i]!=0;
  - j equals prio[i];
  - either dest[i][n]=0, or output n is idle and i is output n's winner.
  In every other case the vote bit is 0.
REQ-023 o_p_o is all-zero in the VOTE cycle. i_p_r is sampled only in COMMIT and ignored in VOTE.
REQ-024 In COMMIT, an input i is granted when any bit of i_p_r in column i is set. For each granted input i:
  - o_deq[i]=1 in the next cycle;
  - every output n with snapshot dest[i][n]=1 has busy_cnt[n] loaded with max(len[i],1);
  - rr_ptr[n] is set to (i+1) mod N.
REQ-025 o_err is set and the grant is dropped (no o_deq, no load) in either case:
  - a grant bit j*N+i has the corresponding vote zero at any output n in dest[i];
  - more than one bit is set in column i.
REQ-026 busy_cnt[n] decrements by 1 each cycle while nonzero. A load never coincides with a nonzero count, because only idle outputs elect winners.
REQ-027 o_busy[n] = (busy_cnt[n] != 0).
REQ-028 Cycle-level timing for a request presented in VOTE cycle t:
  - votes are visible in cycle t+1;
  - o_deq pulses in cycle t+2;
  - o_busy is high for exactly len cycles, cycles t+2 to t+1+len.
REQ-029 Sources may change requests after the VOTE edge; the grant uses the snapshot.
REQ-030 A busy output votes 1 only for inputs whose dest excludes it.

Reset
REQ-031 On i_rst=1 at a clock edge, the block enters the following state:
  - FSM in VOTE;
  - o_p_o, busy_cnt, rr_ptr, o_deq and o_err all zero;
  - snapshot registers cleared.
REQ-032 Reset during COMMIT drops the pending grant: no o_deq pulse, no busy load.

Structure
REQ-033 Package fpf_pkg holds N, P, PW, LW, the bit-index helper functions for the o_p_o and i_p_r layouts, and the FSM state enum.
REQ-034 Sub-module rr_priority_picker computes one output's winner from the candidate mask, priorities and rr_ptr. It is instantiated N times.

Verification
REQ-035 The bench closes the loop through the mask-computation stage with N=4, P=4, LW=4.
REQ-036 Unicast: input 2, prio 3, dest 0b0001, len 3 -> o_deq[2] in cycle 2, o_busy[0] high in cycles 2-4, idle in cycle 5.
REQ-037 Priority conflict: input 0 prio 1 and input 1 prio 3, both dest 0b0010 -> only input 1 dequeued; input 0 granted after input 1's len expires.
REQ-038 Round-robin: inputs 0 and 3 at prio 2, dest 0b0100, len 1, held continuously -> grants alternate 0, 3, 0, 3.
REQ-039 Multicast blocking: input 1 dest 0b0011 while output 0 is busy -> vote [0][p][1]=0, no grant, output 1 stays idle; grant issued once output 0 frees.
REQ-040 Error and reset:
  - a forced i_p_r bit on an unvoted input -> o_err=1 and no o_deq;
  - i_rst asserted in COMMIT -> no o_deq, all o_busy=0, and o_err cleared.
